jtsdram_bank_resp: RTL and testbench
====================================

Name: jtsdram_bank_resp

Overview:
- Responder end of the four-bank SDRAM request interface driven by the SDRAM tester game logic.
- Accepts rd/wr requests on banks 0-3 and returns the ack/rdy handshake plus 32-bit data_read.
- Each bank is backed by small on-chip memory, so the tester/checker runs in simulation and on FPGA without a real SDRAM controller.
- Supports round-robin arbitration, fixed access latency and optional refresh stalls.

Parameters:
AW, 10, word-address bits stored per bank; addr[AW-1:0] used, upper bits ignored
LAT, 4, cycles from ack to rdy; legal range 2..15
REF_PERIOD, 384, cycles between refresh requests when refresh_en=1
REF_CYC, 6, busy cycles per refresh

Ports:
clk  in  1  system clock (48 MHz)
rst_n  in  1  asynchronous active-low reset
ba0_addr  in  22  bank 0 word address
ba0_rd  in  1  bank 0 read request, held until ack
ba0_wr  in  1  bank 0 write request, held until ack
ba0_din  in  16  bank 0 write data
ba0_din_m  in  2  write byte mask; 1 = byte not written; bit0 = [7:0]
ba0_ack  out  1  one-cycle pulse: request accepted
ba0_rdy  out  1  one-cycle pulse: read data valid or write done
ba1_addr / ba2_addr / ba3_addr  in  22  read-only bank addresses
ba1_rd / ba2_rd / ba3_rd  in  1  read requests
ba1_ack / ba2_ack / ba3_ack  out  1  accept pulses
ba1_rdy / ba2_rdy / ba3_rdy  out  1  data-valid pulses
data_read  out  32  {word[addr+1], word[addr]} of the last completed read
refresh_en  in  1  enables periodic refresh stalls

Behaviour:
- Reset (async, rst_n=0): all ack/rdy = 0, data_read = 0, state = IDLE, RR pointer = bank 0, refresh counter = 0, no refresh pending. Memory contents are not cleared.
- States:
  - IDLE: refresh pending has priority. Otherwise grant the first requesting bank in round-robin order, starting after the last granted bank (bank 0 first after reset). Grant cycle: latch addr/din/mask/op, pulse that bank's ack for exactly 1 cycle, load latency counter with LAT-1, go to BUSY. If no request, stay in IDLE.
  - BUSY: counter decrements. Memory is read/written once, on the first BUSY cycle. At counter = 0 go to DONE.
  - DONE: pulse that bank's rdy for 1 cycle. On a read, update data_read in the same cycle as rdy. Return to IDLE.
  - REFRESH: stay REF_CYC cycles, clear pending, return to IDLE.
- Timing:
  - ack asserts 1 cycle after the request is first sampled in IDLE.
  - rdy asserts exactly LAT cycles after ack.
  - Back-to-back minimum request spacing: LAT+2 cycles.
- Requests and operations:
  - ba0_rd and ba0_wr both high: treated as a write.
  - A request dropped before ack is not serviced.
  - Requests held after ack are re-arbitrated as new requests.
- Read data:
  - data_read[15:0] = mem[addr].
  - data_read[31:16] = mem[(addr+1) mod 2^AW], wrapping within the bank.
  - data_read holds its value between rdy pulses, including across writes.
- Write: only bytes whose mask bit is 0 are updated; din_m = 2'b11 completes the handshake with no memory change.
- Refresh:
  - Free-running counter counts while refresh_en = 1; it resets and clears pending when refresh_en = 0.
  - Pending is set at REF_PERIOD-1.
  - Pending is serviced only from IDLE and never aborts an access in flight.
- Only one access is outstanding at a time; at most one ack and one rdy are high in any cycle.
- Reset mid-access: handshake abandoned, no rdy issued; a memory write already performed remains.

Optional Feature:
JTSDRAM_ERRINJ_EN
- Defined: an internal read counter increments on every completed read. On every 64th completed read, data_read bit 0 is inverted (memory itself is unchanged). This lets the checker's bad/baN_bad paths be exercised.
- Not defined: the counter and inversion logic are absent; data is always exact.

Test Plan:
1. Reset, then ba0 write addr=5, din=16'hA55A, mask=00, followed by ba0 read addr=5 -> ack 1 cycle after rd; rdy exactly LAT (4) cycles later; data_read[15:0] = 16'hA55A.
2. ba0 write addr=9, din=16'h1234, mask=01 over prior 16'hFFFF -> a subsequent read returns 16'h12FF; mask=11 leaves memory unchanged but still pulses rdy.
3. Banks 1, 2 and 3 raise rd in the same cycle and hold until ack -> acks come in order 1, 2, 3; with ba0 added, order continues 0, 1, ...; never two acks in one cycle.
4. Read at addr = 2^AW-1 (1023) after writing words 0 and 1023 -> data_read = {mem[0], mem[1023]}.
5. refresh_en=1 with ba1 requesting continuously -> a 6-cycle REFRESH gap every 384 cycles; an in-flight access completes before refresh; refresh_en=0 -> no gaps.
6. Assert rst_n=0 during BUSY -> all outputs 0 asynchronously, no rdy after release; with JTSDRAM_ERRINJ_EN defined, the 64th read returns bit 0 inverted.

Source files
------------

// File: rtl/jtsdram_bank_resp.sv
// Four-bank SDRAM request responder backed by on-chip RAM, for running the SDRAM tester without a controller.
// Build macro JTSDRAM_ERRINJ_EN: flip data_read[0] on every 64th completed read.
module jtsdram_bank_resp #(
  parameter int AW         = 10,
  parameter int LAT        = 4,
  parameter int REF_PERIOD = 384,
  parameter int REF_CYC    = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [21:0] ba0_addr,
  input  logic        ba0_rd,
  input  logic        ba0_wr,
  input  logic [15:0] ba0_din,
  input  logic [1:0]  ba0_din_m,
  output logic        ba0_ack,
  output logic        ba0_rdy,
  input  logic [21:0] ba1_addr,
  input  logic        ba1_rd,
  output logic        ba1_ack,
  output logic        ba1_rdy,
  input  logic [21:0] ba2_addr,
  input  logic        ba2_rd,
  output logic        ba2_ack,
  output logic        ba2_rdy,
  input  logic [21:0] ba3_addr,
  input  logic        ba3_rd,
  output logic        ba3_ack,
  output logic        ba3_rdy,
  output logic [31:0] data_read,
  input  logic        refresh_en
);

  // state   | meaning
  // IDLE    | arbitrate: pending refresh first, then round-robin bank grant
  // BUSY    | latency countdown; memory touched on first cycle
  // DONE    | rdy pulse, data_read update on reads
  // REFRESH | REF_CYC stall cycles
  typedef enum logic [1:0] {IDLE, BUSY, DONE, REFRESH} state_t;

  localparam int RCW = $clog2(REF_PERIOD);
  localparam int RBW = $clog2(REF_CYC + 1);
  localparam logic [3:0]     LAT_M1    = 4'(LAT - 1);
  localparam logic [RCW-1:0] REF_LAST  = RCW'(REF_PERIOD - 1);
  localparam logic [RBW-1:0] REF_BUSY0 = RBW'(REF_CYC - 1);

  state_t         state;
  logic [1:0]     prio;
  logic [1:0]     bank;
  logic           op_wr;
  logic [AW-1:0]  addr_q;
  logic [AW-1:0]  addr_nx;
  logic [15:0]    din_q;
  logic [1:0]     mask_q;
  logic [3:0]     lat_cnt;
  logic [RBW-1:0] ref_busy;
  logic [RCW-1:0] ref_cnt;
  logic           ref_pend;
  logic [3:0]     ack;
  logic [3:0]     rdy;
  logic [31:0]    rd_word;
  logic           err_flip;

  logic [3:0]     req;
  logic           gnt_vld;
  logic [1:0]     gnt;
  logic [AW-1:0]  addr_sel;

  logic [15:0] mem [0:(4 << AW) - 1];

  logic unused_addr_hi;
  assign unused_addr_hi = ^{ba0_addr[21:AW], ba1_addr[21:AW], ba2_addr[21:AW], ba3_addr[21:AW]};

  assign {ba3_ack, ba2_ack, ba1_ack, ba0_ack} = ack;
  assign {ba3_rdy, ba2_rdy, ba1_rdy, ba0_rdy} = rdy;

  assign req     = {ba3_rd, ba2_rd, ba1_rd, ba0_rd | ba0_wr};
  assign addr_nx = addr_q + 1'b1;

  // Scan from the far end so the bank closest after the pointer wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt     = prio;
    for (int i = 3; i >= 0; i--) begin
      if (req[prio + 2'(i)]) begin
        gnt_vld = 1'b1;
        gnt     = prio + 2'(i);
      end
    end
  end

  always_comb begin
    case (gnt)
      2'd0:    addr_sel = ba0_addr[AW-1:0];
      2'd1:    addr_sel = ba1_addr[AW-1:0];
      2'd2:    addr_sel = ba2_addr[AW-1:0];
      default: addr_sel = ba3_addr[AW-1:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (state == BUSY && lat_cnt == LAT_M1) begin
      if (op_wr) begin
        if (!mask_q[0]) mem[{bank, addr_q}][7:0]  <= din_q[7:0];
        if (!mask_q[1]) mem[{bank, addr_q}][15:8] <= din_q[15:8];
      end else begin
        rd_word <= {mem[{bank, addr_nx}], mem[{bank, addr_q}]};
      end
    end
  end

`ifdef JTSDRAM_ERRINJ_EN
  logic [5:0] rd_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt <= '0;
    end else if (state == BUSY && lat_cnt == '0 && !op_wr) begin
      rd_cnt <= rd_cnt + 1'b1;
    end
  end

  assign err_flip = (rd_cnt == 6'd63);
`else
  assign err_flip = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      prio      <= 2'd0;
      bank      <= 2'd0;
      op_wr     <= 1'b0;
      addr_q    <= '0;
      din_q     <= 16'd0;
      mask_q    <= 2'd0;
      lat_cnt   <= 4'd0;
      ref_busy  <= '0;
      ref_cnt   <= '0;
      ref_pend  <= 1'b0;
      ack       <= 4'd0;
      rdy       <= 4'd0;
      data_read <= 32'd0;
    end else begin
      ack <= 4'd0;
      rdy <= 4'd0;

      if (!refresh_en) begin
        ref_cnt  <= '0;
        ref_pend <= 1'b0;
      end else if (ref_cnt == REF_LAST) begin
        ref_cnt  <= '0;
        ref_pend <= 1'b1;
      end else begin
        ref_cnt <= ref_cnt + 1'b1;
        if (state == REFRESH && ref_busy == '0) ref_pend <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (ref_pend) begin
            ref_busy <= REF_BUSY0;
            state    <= REFRESH;
          end else if (gnt_vld) begin
            ack[gnt] <= 1'b1;
            bank     <= gnt;
            prio     <= gnt + 2'd1;
            addr_q   <= addr_sel;
            din_q    <= ba0_din;
            mask_q   <= ba0_din_m;
            op_wr    <= (gnt == 2'd0) && ba0_wr;
            lat_cnt  <= LAT_M1;
            state    <= BUSY;
          end
        end
        BUSY: begin
          lat_cnt <= lat_cnt - 4'd1;
          if (lat_cnt == 4'd0) begin
            rdy[bank] <= 1'b1;
            if (!op_wr) data_read <= rd_word ^ {31'd0, err_flip};
            state <= DONE;
          end
        end
        DONE: state <= IDLE;
        REFRESH: begin
          ref_busy <= ref_busy - 1'b1;
          if (ref_busy == '0) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtsdram_bank_resp.sv
// Randomized bench for jtsdram_bank_resp: a timestamp-based transaction model predicts ack/rdy/data_read every cycle.
module tb_jtsdram_bank_resp;
  localparam int AW = 10, LAT = 4, REF_PERIOD = 384, REF_CYC = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [21:0] ba0_addr = '0, ba1_addr = '0, ba2_addr = '0, ba3_addr = '0;
  logic        ba0_rd = 0, ba0_wr = 0, ba1_rd = 0, ba2_rd = 0, ba3_rd = 0;
  logic [15:0] ba0_din = '0;
  logic [1:0]  ba0_din_m = '0;
  logic        ba0_ack, ba1_ack, ba2_ack, ba3_ack;
  logic        ba0_rdy, ba1_rdy, ba2_rdy, ba3_rdy;
  logic [31:0] data_read;
  logic        refresh_en = 1'b0;
  logic [3:0]  ack_v, rdy_v;

  assign ack_v = {ba3_ack, ba2_ack, ba1_ack, ba0_ack};
  assign rdy_v = {ba3_rdy, ba2_rdy, ba1_rdy, ba0_rdy};

  always #10 clk = ~clk;

  jtsdram_bank_resp #(.AW(AW), .LAT(LAT), .REF_PERIOD(REF_PERIOD), .REF_CYC(REF_CYC)) dut (
    .clk(clk), .rst_n(rst_n),
    .ba0_addr(ba0_addr), .ba0_rd(ba0_rd), .ba0_wr(ba0_wr), .ba0_din(ba0_din), .ba0_din_m(ba0_din_m),
    .ba0_ack(ba0_ack), .ba0_rdy(ba0_rdy),
    .ba1_addr(ba1_addr), .ba1_rd(ba1_rd), .ba1_ack(ba1_ack), .ba1_rdy(ba1_rdy),
    .ba2_addr(ba2_addr), .ba2_rd(ba2_rd), .ba2_ack(ba2_ack), .ba2_rdy(ba2_rdy),
    .ba3_addr(ba3_addr), .ba3_rd(ba3_rd), .ba3_ack(ba3_ack), .ba3_rdy(ba3_rdy),
    .data_read(data_read), .refresh_en(refresh_en)
  );

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model (event timestamps, not states) ----------------
  logic [15:0] mmem [0:1023];
  bit          mknown [0:1023];
  int          edge_n = 0, idle_edge = 0, rdy_edge = -1, ref_done_edge = -1;
  int          ren_cnt = 0, prio = 0, cur_bank = 0, nreads = 0, m_g, m_a;
  bit          pend = 0, cur_wr = 0, d_known = 1, pend_known = 0;
  logic [3:0]  e_ack = '0, e_rdy = '0, m_req;
  logic [31:0] e_data = '0, pend_data = '0;

  initial for (int i = 0; i < 1024; i++) mknown[i] = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_ack = '0; e_rdy = '0; e_data = '0; d_known = 1;
      idle_edge = 0; rdy_edge = -1; ref_done_edge = -1;
      ren_cnt = 0; pend = 0; prio = 0; nreads = 0;
    end else begin
      edge_n++;
      e_ack = '0; e_rdy = '0;
      if (edge_n == rdy_edge) begin
        e_rdy[cur_bank] = 1'b1;
        if (!cur_wr) begin
          nreads++;
          e_data = pend_data;
`ifdef JTSDRAM_ERRINJ_EN
          if (nreads % 64 == 0) e_data[0] = ~e_data[0];
`endif
          d_known = pend_known;
        end
      end
      if (edge_n >= idle_edge) begin
        if (pend) begin
          ref_done_edge = edge_n + REF_CYC;
          idle_edge     = edge_n + REF_CYC + 1;
        end else begin
          m_req = {ba3_rd, ba2_rd, ba1_rd, ba0_rd | ba0_wr};
          m_g = -1;
          for (int k = 0; k < 4; k++) if (m_g < 0 && m_req[(prio + k) % 4]) m_g = (prio + k) % 4;
          if (m_g >= 0) begin
            e_ack[m_g] = 1'b1;
            cur_bank   = m_g;
            prio       = (m_g + 1) % 4;
            cur_wr     = (m_g == 0) && ba0_wr;
            rdy_edge   = edge_n + LAT;
            idle_edge  = edge_n + LAT + 2;
            case (m_g)
              0: m_a = int'(ba0_addr[9:0]);
              1: m_a = int'(ba1_addr[9:0]);
              2: m_a = int'(ba2_addr[9:0]);
              default: m_a = int'(ba3_addr[9:0]);
            endcase
            if (cur_wr) begin
              if (!ba0_din_m[0]) mmem[m_a][7:0]  = ba0_din[7:0];
              if (!ba0_din_m[1]) mmem[m_a][15:8] = ba0_din[15:8];
              if (ba0_din_m == 2'b00) mknown[m_a] = 1;
            end else if (m_g == 0) begin
              pend_data  = {mmem[(m_a + 1) % 1024], mmem[m_a]};
              pend_known = mknown[m_a] && mknown[(m_a + 1) % 1024];
            end else begin
              pend_known = 0;
            end
          end
        end
      end
      if (!refresh_en) begin
        ren_cnt = 0; pend = 0;
      end else begin
        ren_cnt++;
        if (ren_cnt % REF_PERIOD == 0) pend = 1;
        else if (edge_n == ref_done_edge) pend = 0;
      end
    end
  end

  bit checking = 0;
  always @(negedge clk) if (checking) begin
    chk("ack", {28'd0, ack_v}, {28'd0, e_ack});
    chk("rdy", {28'd0, rdy_v}, {28'd0, e_rdy});
    if (d_known) chk("data_read", data_read, e_data);
  end

  // ---------------- stimulus helpers ----------------
  task automatic access(input bit wr, input logic [21:0] a, input logic [15:0] d, input logic [1:0] m,
                        output int t_ack, output int t_rdy);
    ba0_addr = a; ba0_din = d; ba0_din_m = m; ba0_wr = wr; ba0_rd = !wr;
    t_ack = 0;
    do begin @(negedge clk); t_ack++; end while (!ba0_ack && t_ack < 100);
    ba0_rd = 0; ba0_wr = 0;
    t_rdy = 0;
    do begin @(negedge clk); t_rdy++; end while (!ba0_rdy && t_rdy < 100);
    @(negedge clk);
    if (t_ack >= 100 || t_rdy >= 100) begin
      n_chk++;
      $display("FAIL handshake_timeout: ack after %0d rdy after %0d cycles, required under 100", t_ack, t_rdy);
    end
  endtask

  task automatic drop(input int b);
    case (b)
      0: begin ba0_rd = 0; ba0_wr = 0; end
      1: ba1_rd = 0;
      2: ba2_rd = 0;
      default: ba3_rd = 0;
    endcase
  endtask

  task automatic raise_rand(input int b);
    int idx, kind;
    idx = $urandom_range(0, 31);
    case (b)
      0: begin
        ba0_addr  = {12'($urandom), 10'(idx < 16 ? idx : 1008 + idx - 16)};
        ba0_din   = 16'($urandom);
        ba0_din_m = 2'($urandom);
        kind      = $urandom_range(0, 2);
        ba0_rd    = (kind != 1);
        ba0_wr    = (kind != 0);
      end
      1: begin ba1_addr = 22'($urandom); ba1_rd = 1; end
      2: begin ba2_addr = 22'($urandom); ba2_rd = 1; end
      default: begin ba3_addr = 22'($urandom); ba3_rd = 1; end
    endcase
  endtask

  int ack_order[$];

  task automatic multi(input logic [3:0] banks);
    logic [3:0] on;
    on = banks;
    ack_order.delete();
    ba0_addr = 22'd5; ba0_rd = on[0]; ba0_wr = 0;
    ba1_addr = 22'($urandom); ba1_rd = on[1];
    ba2_addr = 22'($urandom); ba2_rd = on[2];
    ba3_addr = 22'($urandom); ba3_rd = on[3];
    for (int c = 0; c < 100 && on != 0; c++) begin
      @(negedge clk);
      for (int b = 0; b < 4; b++) if (ack_v[b]) begin ack_order.push_back(b); on[b] = 0; drop(b); end
    end
    repeat (LAT + 3) @(negedge clk);
  endtask

  function automatic int order_code();
    int code = 0;
    foreach (ack_order[i]) code = code * 10 + ack_order[i] + 1;
    return code;
  endfunction

  int ta, tr, last, n_short, n_long, n_odd, n_r, idx;
  logic [3:0] on;

  initial begin
    #5 rst_n = 0;
    checking = 1;
    repeat (3) @(negedge clk);
    chk("rst_ack", {28'd0, ack_v}, 32'd0);
    chk("rst_rdy", {28'd0, rdy_v}, 32'd0);
    chk("rst_data", data_read, 32'd0);
    #5 rst_n = 1;
    @(negedge clk);

    for (int i = 0; i < 32; i++) begin
      idx = (i < 16) ? i : 1008 + i - 16;
      access(1, 22'(idx), 16'($urandom), 2'b00, ta, tr);
    end

    // basic write then read with latency
    access(1, 22'd5, 16'hA55A, 2'b00, ta, tr);
    access(0, 22'd5, 16'h0000, 2'b00, ta, tr);
    chk("t1_ack_lat", ta, 1);
    chk("t1_rdy_lat", tr, LAT);
    chk("t1_data", {16'd0, data_read[15:0]}, 32'h0000A55A);

    // byte masks
    access(1, 22'd9, 16'hFFFF, 2'b00, ta, tr);
    access(1, 22'd9, 16'h1234, 2'b01, ta, tr);
    access(0, 22'd9, 16'h0000, 2'b00, ta, tr);
    chk("t2_mask01", {16'd0, data_read[15:0]}, 32'h000012FF);
    access(1, 22'd9, 16'h0000, 2'b11, ta, tr);
    chk("t2_mask11_rdy", tr, LAT);
    access(0, 22'd9, 16'h0000, 2'b00, ta, tr);
    chk("t2_mask11_keep", {16'd0, data_read[15:0]}, 32'h000012FF);

    // round robin
    multi(4'b1110);
    chk("t3_order_123", order_code(), 234);
    multi(4'b1111);
    chk("t3_order_0123", order_code(), 1234);

    // wrap at top of bank, upper address bits ignored
    access(1, 22'h3FFC00, 16'hBEEF, 2'b00, ta, tr);
    access(1, 22'h1553FF, 16'hCAFE, 2'b00, ta, tr);
    access(0, 22'h2AABFF, 16'h0000, 2'b00, ta, tr);
    chk("t4_wrap", data_read, 32'hBEEFCAFE);

    // refresh gaps with a continuous bank 1 requester
    ba1_addr = 22'($urandom); ba1_rd = 1; refresh_en = 1;
    for (int w = 0; w < 2; w++) begin
      last = -1; n_short = 0; n_long = 0; n_odd = 0;
      for (int c = 0; c < (w == 0 ? 900 : 400); c++) begin
        @(negedge clk);
        if (ba1_ack) begin
          if (last >= 0) begin
            if (c - last == LAT + 2) n_short++;
            else if (c - last == LAT + 3 + REF_CYC) n_long++;
            else n_odd++;
          end
          last = c;
        end
      end
      chk(w == 0 ? "t5_gaps_on" : "t5_gaps_off", n_long, w == 0 ? 2 : 0);
      chk("t5_odd_spacing", n_odd, 0);
      refresh_en = 0;
    end
    ba1_rd = 0;
    repeat (20) @(negedge clk);

    // reset during BUSY
    access(0, 22'd5, 16'h0000, 2'b00, ta, tr);
    ba0_addr = 22'd3; ba0_din = 16'h5A5A; ba0_din_m = 2'b00; ba0_wr = 1;
    ta = 0;
    do begin @(negedge clk); ta++; end while (!ba0_ack && ta < 100);
    ba0_wr = 0;
    chk("t6_ack_seen", ta, 1);
    repeat (2) @(negedge clk);
    #5 rst_n = 0;
    #1 chk("t6_async_data", data_read, 32'd0);
    chk("t6_async_hs", {24'd0, ack_v, rdy_v}, 32'd0);
    repeat (2) @(negedge clk);
    #5 rst_n = 1;
    n_r = 0;
    repeat (LAT + 4) begin @(negedge clk); if (rdy_v != 0) n_r++; end
    chk("t6_no_rdy", n_r, 0);
    access(0, 22'd3, 16'h0000, 2'b00, ta, tr);
    chk("t6_write_kept", {16'd0, data_read[15:0]}, 32'h00005A5A);

    // randomized traffic
    on = '0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 599) == 0) refresh_en = ~refresh_en;
      for (int b = 0; b < 4; b++) begin
        if (on[b]) begin
          if (ack_v[b]) begin
            if ($urandom_range(0, 3) != 0) begin on[b] = 0; drop(b); end
          end else if ($urandom_range(0, 19) == 0) begin
            on[b] = 0; drop(b);
          end
        end else if ($urandom_range(0, 3) == 0) begin
          on[b] = 1; raise_rand(b);
        end
      end
    end
    for (int b = 0; b < 4; b++) drop(b);
    refresh_en = 0;
    repeat (30) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
